// File: rtl/tree_outport_allocator.sv
// Output-port allocator for a tree router: round-robin selection among inputs
// whose head flit targets this port, wormhole lock until tail, credit tracking.
module tree_outport_allocator #(
  parameter int K            = 2,
  parameter int P            = K + 1,
  parameter int OUT_PORT     = 0,
  parameter int B            = 4,
  parameter int SELF_LOOP_EN = 0,
  parameter int DSPw         = $clog2(K + 1),
  parameter int CNTw         = $clog2(B + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [P-1:0]      head_valid_i,
  input  logic [P*DSPw-1:0] destport_encoded_i,
  input  logic [P-1:0]      flit_valid_i,
  input  logic [P-1:0]      flit_tail_i,
  input  logic              credit_in_i,
  output logic [P-1:0]      grant_o,
  output logic              busy_o,
  output logic [P-1:0]      flit_rd_o,
  output logic              out_wr_o,
  output logic [CNTw-1:0]   credit_o,
  output logic              credit_err_o
);

  localparam int PTRw = (P > 1) ? $clog2(P) : 1;
  localparam logic [DSPw-1:0] OUT_SEL = DSPw'(OUT_PORT);
  localparam logic [CNTw-1:0] B_CNT   = CNTw'(B);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [PTRw-1:0] rr_ptr;
  logic [P-1:0]    req;
  logic [P-1:0]    pick;
  logic [PTRw-1:0] pick_next;
  logic            xfer;
  logic            owner_tail;

  always_comb begin
    req = '0;
    for (int i = 0; i < P; i++) begin
      if (head_valid_i[i] && (destport_encoded_i[i*DSPw +: DSPw] == OUT_SEL) &&
          ((SELF_LOOP_EN != 0) || (i != OUT_PORT)))
        req[i] = 1'b1;
    end
  end

  // Round-robin: first requester found scanning upward from rr_ptr, wrapping.
  always_comb begin
    logic            found;
    int              idx_int;
    logic [PTRw-1:0] idx;
    pick      = '0;
    pick_next = '0;
    found     = 1'b0;
    idx_int   = 0;
    idx       = '0;
    for (int off = 0; off < P; off++) begin
      idx_int = (int'(rr_ptr) + off) % P;
      idx     = PTRw'(idx_int);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        pick_next = PTRw'((idx_int + 1) % P);
        found     = 1'b1;
      end
    end
  end

  assign xfer       = !reset && (state == BUSY) && (|(flit_valid_i & grant_o)) &&
                      (credit_o != '0);
  assign owner_tail = |(flit_tail_i & grant_o);
  assign out_wr_o   = xfer;
  assign flit_rd_o  = xfer ? grant_o : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant_o      <= '0;
      busy_o       <= 1'b0;
      rr_ptr       <= '0;
      credit_o     <= B_CNT;
      credit_err_o <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (|req) begin
          state   <= BUSY;
          grant_o <= pick;
          busy_o  <= 1'b1;
          rr_ptr  <= pick_next;
        end
      end else if (xfer && owner_tail) begin
        state   <= IDLE;
        grant_o <= '0;
        busy_o  <= 1'b0;
      end

      // A write and a returned credit in the same cycle cancel out.
      if (out_wr_o && !credit_in_i) begin
        credit_o <= credit_o - 1'b1;
      end else if (credit_in_i && !out_wr_o) begin
        if (credit_o == B_CNT)
          credit_err_o <= 1'b1;
        else
          credit_o <= credit_o + 1'b1;
      end
    end
  end

endmodule
